// File: rtl/bank_skew_feeder.sv
// Diagonal-skew read sequencer between the column memory bank and the systolic array.
// Define BANK_SKEW_REVERSE_EN to feed each lane's rows in descending order.
module bank_skew_feeder #(
    parameter int unsigned MatrixSize  = 4,
    parameter int unsigned DataSize    = 16,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic                                         start_i,
    input  logic                                         stall_i,
    input  logic [MatrixSize-1:0][DataSize-1:0]          bank_element_vector_i,
    output logic [MatrixSize-1:0][$clog2(MatrixSize)-1:0] read_location_vector_o,
    output logic [MatrixSize-1:0][DataSize-1:0]          skewed_element_vector_o,
    output logic [MatrixSize-1:0]                        lane_valid_o,
    output logic                                         busy_o,
    output logic                                         done_o
);

    localparam int unsigned AddrW = $clog2(MatrixSize);
    localparam int unsigned StepW = $clog2(2 * MatrixSize);
    localparam int unsigned CntW  = $clog2(ReadLatency + 1);
    localparam logic [StepW-1:0] LastStep = StepW'(2 * MatrixSize - 2);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                              state_q;
    logic [StepW-1:0]                    step_q;
    logic [CntW-1:0]                     drain_q;
    // Top bit of each pipe entry marks the final issue step so done lines up with its beat.
    logic [MatrixSize:0]                 pipe_q [ReadLatency];
    logic [MatrixSize-1:0][DataSize-1:0] skew_q;
    logic [MatrixSize-1:0]               lane_valid_q;
    logic                                done_q;

    logic [MatrixSize-1:0][AddrW-1:0]    issue_addr;
    logic [MatrixSize-1:0]               issue_vld;
    logic                                issue_last;
    logic signed [StepW:0]               diff;
    logic [MatrixSize:0]                 delayed;

    always_comb begin
        issue_addr = '0;
        issue_vld  = '0;
        diff       = '0;
        for (int unsigned i = 0; i < MatrixSize; i++) begin
            diff = $signed({1'b0, step_q}) - $signed((StepW + 1)'(i));
            if (state_q == StIssue && !diff[StepW] &&
                diff < $signed((StepW + 1)'(MatrixSize))) begin
                issue_vld[i] = 1'b1;
`ifdef BANK_SKEW_REVERSE_EN
                issue_addr[i] = AddrW'(MatrixSize - 1) - diff[AddrW-1:0];
`else
                issue_addr[i] = diff[AddrW-1:0];
`endif
            end
        end
        issue_last = (state_q == StIssue) && (step_q == LastStep);
    end

    assign delayed = pipe_q[ReadLatency-1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            step_q       <= '0;
            drain_q      <= '0;
            skew_q       <= '0;
            lane_valid_q <= '0;
            done_q       <= 1'b0;
            for (int unsigned s = 0; s < ReadLatency; s++) begin
                pipe_q[s] <= '0;
            end
        end else if (!stall_i) begin
            pipe_q[0] <= {issue_last, issue_vld};
            for (int unsigned s = 1; s < ReadLatency; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
            for (int unsigned i = 0; i < MatrixSize; i++) begin
                skew_q[i] <= delayed[i] ? bank_element_vector_i[i] : '0;
            end
            lane_valid_q <= delayed[MatrixSize-1:0];
            done_q       <= delayed[MatrixSize];

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StIssue;
                        step_q  <= '0;
                    end
                end
                StIssue: begin
                    if (step_q == LastStep) begin
                        state_q <= StDrain;
                        drain_q <= '0;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                StDrain: begin
                    // Final drain cycle is the one in which done is shown.
                    if (drain_q == CntW'(ReadLatency)) begin
                        state_q <= StIdle;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign read_location_vector_o  = issue_addr;
    assign skewed_element_vector_o = skew_q;
    assign lane_valid_o            = lane_valid_q;
    assign busy_o                  = (state_q != StIdle);
    assign done_o                  = done_q;

endmodule

// File: tb/tb_bank_skew_feeder.sv
// Bench for bank_skew_feeder: ReadLatency 1 and 2 instances share stimulus and are
// compared each cycle against a timeline model driven by the count of non-stalled edges.
module tb_bank_skew_feeder;

    localparam int N = 4;
    localparam int D = 16;
    localparam int A = $clog2(N);
`ifdef BANK_SKEW_REVERSE_EN
    localparam bit Rev = 1'b1;
`else
    localparam bit Rev = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_i, start_i, stall_i;
    always #5 clk_i = ~clk_i;

    logic [N-1:0][D-1:0] bank1, bank2s, bank2;
    logic [N-1:0][A-1:0] addr1, addr2;
    logic [N-1:0][D-1:0] skew1, skew2;
    logic [N-1:0]        vld1, vld2;
    logic                busy1, busy2, done1, done2;

    bank_skew_feeder #(.MatrixSize(N), .DataSize(D), .ReadLatency(1)) u_dut_l1 (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .start_i                (start_i),
        .stall_i                (stall_i),
        .bank_element_vector_i  (bank1),
        .read_location_vector_o (addr1),
        .skewed_element_vector_o(skew1),
        .lane_valid_o           (vld1),
        .busy_o                 (busy1),
        .done_o                 (done1)
    );

    bank_skew_feeder #(.MatrixSize(N), .DataSize(D), .ReadLatency(2)) u_dut_l2 (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .start_i                (start_i),
        .stall_i                (stall_i),
        .bank_element_vector_i  (bank2),
        .read_location_vector_o (addr2),
        .skewed_element_vector_o(skew2),
        .lane_valid_o           (vld2),
        .busy_o                 (busy2),
        .done_o                 (done2)
    );

    // Bank contents and a read pipe that holds with the same stall as the feeder.
    logic [D-1:0] mem [N][N];
    always @(posedge clk_i) begin
        if (!stall_i) begin
            for (int i = 0; i < N; i++) begin
                bank1[i]  <= mem[i][addr1[i]];
                bank2s[i] <= mem[i][addr2[i]];
                bank2[i]  <= bank2s[i];
            end
        end
    end

    // Model: a feed is a timeline indexed by e, the non-stalled edges since the start edge.
    bit act [2];
    int e   [2];
    always @(posedge clk_i) begin
        for (int j = 0; j < 2; j++) begin
            if (reset_i) begin
                act[j] <= 1'b0;
                e[j]   <= 0;
            end else if (!stall_i) begin
                if (!act[j]) begin
                    if (start_i) begin
                        act[j] <= 1'b1;
                        e[j]   <= 0;
                    end
                end else if (e[j] == 2 * N + (j + 1) - 1) begin
                    act[j] <= 1'b0;
                end else begin
                    e[j] <= e[j] + 1;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int row_of(input int r);
        return Rev ? (N - 1 - r) : r;
    endfunction

    task automatic compare_inst(input int j, input logic [N-1:0][A-1:0] a,
                                input logic [N-1:0][D-1:0] d, input logic [N-1:0] v,
                                input logic b, input logic dn);
        int lat;
        int r;
        logic [N-1:0][A-1:0] ea;
        logic [N-1:0][D-1:0] ed;
        logic [N-1:0]        ev;
        logic                eb, edn;
        lat = j + 1;
        ea  = '0;
        ed  = '0;
        ev  = '0;
        eb  = 1'b0;
        edn = 1'b0;
        if (act[j]) begin
            eb  = 1'b1;
            edn = (e[j] == 2 * N + lat - 1);
            for (int i = 0; i < N; i++) begin
                r = e[j] - i;
                if (e[j] <= 2 * N - 2 && r >= 0 && r < N) ea[i] = A'(row_of(r));
                r = e[j] - 1 - lat - i;
                if (r >= 0 && r < N) begin
                    ev[i] = 1'b1;
                    ed[i] = mem[i][row_of(r)];
                end
            end
        end
        check_eq($sformatf("L%0d addr", lat), 128'(a), 128'(ea));
        check_eq($sformatf("L%0d data", lat), 128'(d), 128'(ed));
        check_eq($sformatf("L%0d valid", lat), 128'(v), 128'(ev));
        check_eq($sformatf("L%0d busy", lat), 128'(b), 128'(eb));
        check_eq($sformatf("L%0d done", lat), 128'(dn), 128'(edn));
    endtask

    task automatic step(input logic st, input logic sl, input logic rs);
        start_i = st;
        stall_i = sl;
        reset_i = rs;
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        compare_inst(0, addr1, skew1, vld1, busy1, done1);
        compare_inst(1, addr2, skew2, vld2, busy2, done2);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++)
            for (int r = 0; r < N; r++) mem[i][r] = D'(10 * i + r);
        start_i = 1'b0;
        stall_i = 1'b0;
        reset_i = 1'b1;

        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        idle(2);

        // Basic feed.
        step(1'b1, 1'b0, 1'b0);
        idle(13);

        // Three-cycle stall once the step counter reaches 3.
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0);
        idle(13);

        // Second start while busy is ignored.
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        idle(12);

        // Reset mid-feed, then a fresh feed.
        step(1'b1, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        idle(13);

        // Start held high through a done cycle and into idle, with stalls.
        step(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 14; c++) step(1'b1, (c == 10), 1'b0);
        idle(12);

        for (int c = 0; c < 3000; c++) begin
            if (!act[0] && !act[1] && ($urandom_range(0, 7) == 0)) begin
                for (int i = 0; i < N; i++)
                    for (int r = 0; r < N; r++) mem[i][r] = D'($urandom);
            end
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 79) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
